// File: rtl/seq_divider_8x4_pkg.sv
// Shared definitions for the 8-by-4 sequential restoring divider.
package seq_divider_8x4_pkg;

  localparam int DVD_W_DEF = 8;
  localparam int DVS_W_DEF = 4;

  function automatic int cnt_width(input int dvd_w);
    return $clog2(dvd_w + 1);
  endfunction

  localparam int CNT_W_DEF = cnt_width(DVD_W_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_8x4_div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// trial-subtract the divisor, keep the difference if it did not borrow.
module seq_divider_8x4_div_step #(
  parameter int DVS_W = 4
) (
  input  logic [DVS_W-1:0] r_in,
  input  logic             dvd_bit,
  input  logic [DVS_W-1:0] divisor,
  output logic [DVS_W-1:0] r_out,
  output logic             q_bit
);

  logic [DVS_W:0] shifted;
  logic [DVS_W:0] diff;

  assign shifted = {r_in, dvd_bit};
  assign diff    = shifted - {1'b0, divisor};

  // r_in < divisor always holds, so shifted < 2*divisor and a successful
  // subtract leaves diff < divisor; the MSB is therefore a pure borrow flag.
  assign q_bit = ~diff[DVS_W];
  assign r_out = q_bit ? diff[DVS_W-1:0] : shifted[DVS_W-1:0];

endmodule

// File: rtl/seq_divider_8x4.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// The dividend register doubles as the quotient shift register.
module seq_divider_8x4
  import seq_divider_8x4_pkg::*;
#(
  parameter int DVD_W = DVD_W_DEF,
  parameter int DVS_W = DVS_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(DVD_W);

  state_t           state, state_nxt;
  logic [DVD_W-1:0] dvd_reg;
  logic [DVS_W-1:0] dvs_reg;
  logic [DVS_W-1:0] r_reg;
  logic [CW-1:0]    cnt;
  logic             dz_pend;
  logic [DVS_W-1:0] r_next;
  logic             q_bit;
  logic             last;

  seq_divider_8x4_div_step #(.DVS_W(DVS_W)) u_step (
    .r_in    (r_reg),
    .dvd_bit (dvd_reg[DVD_W-1]),
    .divisor (dvs_reg),
    .r_out   (r_next),
    .q_bit   (q_bit)
  );

  assign last = (cnt == CW'(1));
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      dvd_reg     <= '0;
      dvs_reg     <= '0;
      r_reg       <= '0;
      cnt         <= '0;
      dz_pend     <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            dvd_reg <= dividend;
            dvs_reg <= divisor;
            r_reg   <= '0;
            dz_pend <= (divisor == '0);
            // A zero divisor spends a single cycle in CALC before DONE.
            cnt     <= (divisor == '0) ? CW'(1) : CW'(DVD_W);
          end
        end
        CALC: begin
          dvd_reg <= {dvd_reg[DVD_W-2:0], q_bit};
          r_reg   <= r_next;
          cnt     <= cnt - CW'(1);
          if (last) begin
            if (dz_pend) begin
              quotient    <= '1;
              remainder   <= '0;
              div_by_zero <= 1'b1;
            end else begin
              quotient    <= {dvd_reg[DVD_W-2:0], q_bit};
              remainder   <= r_next;
              div_by_zero <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_8x4.sv
// Scoreboard bench for seq_divider_8x4: stimulus pushes expected results,
// a monitor pops and compares them on every done pulse.
module tb_seq_divider_8x4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient;
  logic [3:0] remainder;

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       dz;
    int         lat;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  seq_divider_8x4 dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (!busy) return;
      tick();
    end
    chk("idle_timeout", 0, 1);
  endtask

  // Issue one division and record what the monitor must see.
  task automatic do_div(input int a, input int b, input int q, input int r, input int dz);
    exp_t e;
    wait_idle();
    dividend = 8'(a);
    divisor  = 4'(b);
    start    = 1'b1;
    tick();
    start = 1'b0;
    e.q   = 8'(q);
    e.r   = 4'(r);
    e.dz  = dz[0];
    e.lat = (b == 0) ? 1 : 8;
    e.acc = cyc;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      tick();
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("quotient", int'(quotient), int'(e.q));
          chk("remainder", int'(remainder), int'(e.r));
          chk("div_by_zero", int'(div_by_zero), int'(e.dz));
          chk("latency", cyc - e.acc, e.lat);
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int qv [5];
    int av [5];
    int bv [5];
    av = '{1, 6, 30, 63, 225};
    bv = '{1, 3, 6, 7, 15};
    qv = '{1, 2, 5, 9, 15};

    // Reset with start asserted: start must be ignored.
    rst = 1'b1; start = 1'b1; dividend = 8'd30; divisor = 4'd6;
    repeat (3) tick();
    rst = 1'b0; start = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_quotient", int'(quotient), 0);
    chk("rst_remainder", int'(remainder), 0);
    chk("rst_dz", int'(div_by_zero), 0);
    tick();
    chk("post_rst_busy", int'(busy), 0);

    // Multiplier round-trip vectors, busy checked through to done.
    for (int i = 0; i < 5; i++) begin
      do_div(av[i], bv[i], qv[i], 0, 0);
      for (int j = 0; j <= 8; j++) begin
        chk("rt_busy", int'(busy), 1);
        if (j < 8) tick();
      end
      wait_idle();
    end

    do_div(200, 3, 66, 2, 0);
    do_div(255, 1, 255, 0, 0);
    do_div(7, 15, 0, 7, 0);
    do_div(0, 9, 0, 0, 0);

    do_div(37, 0, 255, 0, 1);
    do_div(37, 5, 7, 2, 0);
    wait_idle();

    // start during CALC is ignored; outputs hold the previous result.
    do_div(100, 7, 14, 2, 0);
    tick();
    tick();
    start = 1'b1; dividend = 8'd50; divisor = 4'd5;
    chk("hold_quotient", int'(quotient), 7);
    chk("hold_remainder", int'(remainder), 2);
    chk("mid_busy", int'(busy), 1);
    tick();
    start = 1'b0;
    wait_idle();
    repeat (12) tick();

    // Abort mid-operation with reset: no done, outputs cleared.
    dividend = 8'd225; divisor = 4'd15; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_quotient", int'(quotient), 0);
    chk("abort_remainder", int'(remainder), 0);
    chk("abort_dz", int'(div_by_zero), 0);
    repeat (12) tick();
    do_div(30, 6, 5, 0, 0);
    wait_idle();

    // Exhaustive sweep over all nonzero divisors.
    for (int a = 0; a < 256; a++)
      for (int b = 1; b < 16; b++)
        do_div(a, b, a / b, a % b, 0);
    wait_idle();
    repeat (3) tick();
    chk("scoreboard_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
